// File: rtl/host_fifo_packer_pkg.sv
// Shared definitions for the host FIFO word path, used by both the packer
// and the host interface unpacker.
package host_if_pkg;

  localparam int HOST_DATA_W = 64;
  localparam int HOST_LEN_W  = 3;
  localparam int HOST_BUF_W  = 8;
  localparam int HOST_WORD_W = 77;

  // Field order matches the FIFO word: {buffer, length, sop, eop, data}.
  typedef struct packed {
    logic [HOST_BUF_W-1:0]  buffer;
    logic [HOST_LEN_W-1:0]  length;
    logic                   sop;
    logic                   eop;
    logic [HOST_DATA_W-1:0] data;
  } host_word_t;

  typedef enum logic [1:0] {
    IDLE,
    IN_PKT,
    DROP
  } packer_state_t;

endpackage

// File: rtl/host_fifo_packer_if.sv
// Upstream beat stream, host FIFO write port and status counters of the packer.
interface host_fifo_packer_if;
  import host_if_pkg::*;

  logic                   in_valid;
  logic                   in_ready;
  logic [HOST_DATA_W-1:0] in_data;
  logic [HOST_LEN_W-1:0]  in_length;
  logic                   in_sop;
  logic                   in_eop;
  logic                   fifo_full;
  logic                   wr_en;
  logic [HOST_WORD_W-1:0] wr_data;
  logic [15:0]            pkt_cnt;
  logic [15:0]            drop_cnt;
  logic [7:0]             err_cnt;

  // The master side sources beats and models the FIFO.
  modport master (
    output in_valid, in_data, in_length, in_sop, in_eop, fifo_full,
    input  in_ready, wr_en, wr_data, pkt_cnt, drop_cnt, err_cnt
  );

  modport slave (
    input  in_valid, in_data, in_length, in_sop, in_eop, fifo_full,
    output in_ready, wr_en, wr_data, pkt_cnt, drop_cnt, err_cnt
  );

endinterface

// File: rtl/host_fifo_packer_skid.sv
// Single-entry holding register in front of the host FIFO; reloads on the
// same cycle it drains so back-to-back beats see no bubble.
module host_fifo_skid #(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             full_i,
  output logic             ready_o,
  output logic             wr_en_o,
  output logic [WIDTH-1:0] wr_data_o
);

  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_word_q, hold_word_d;

  assign wr_en_o   = rst_ni && hold_valid_q && !full_i;
  assign ready_o   = rst_ni && (!hold_valid_q || !full_i);
  assign wr_data_o = (rst_ni && hold_valid_q) ? hold_word_q : '0;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_word_d  = hold_word_q;
    if (load_i) begin
      hold_valid_d = 1'b1;
      hold_word_d  = data_i;
    end else if (wr_en_o) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
    end
  end

endmodule

// File: rtl/host_fifo_packer.sv
// Packs upstream beats into host FIFO words, assigns per-packet buffer ids
// and polices framing (orphans, missing eop, oversize packets).
module host_fifo_packer
  import host_if_pkg::*;
#(
  parameter int                    MAX_BEATS   = 32,
  parameter logic [HOST_BUF_W-1:0] BUF_ID_INIT = 8'h00
) (
  input logic              clk_host,
  input logic              rst_n,
  host_fifo_packer_if.slave bus
);

  packer_state_t         state_q, state_d;
  logic [7:0]            beat_cnt_q, beat_cnt_d;
  logic [HOST_BUF_W-1:0] buf_id_q, buf_id_d, word_buf;
  logic                  drop_open_q, drop_open_d;
  logic [15:0]           pkt_cnt_q, pkt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [7:0]            err_cnt_q, err_cnt_d;
  logic                  accept, write_beat, pkt_inc, drop_inc, err_inc;
  logic                  in_ready;
  host_word_t            word;

  assign accept      = bus.in_valid && in_ready;
  assign bus.in_ready = in_ready;
  assign bus.pkt_cnt  = rst_n ? pkt_cnt_q  : '0;
  assign bus.drop_cnt = rst_n ? drop_cnt_q : '0;
  assign bus.err_cnt  = rst_n ? err_cnt_q  : '0;

  // drop_open_q remembers whether the packet being discarded still owes a buffer id.
  always_comb begin
    state_d     = state_q;
    beat_cnt_d  = beat_cnt_q;
    buf_id_d    = buf_id_q;
    drop_open_d = drop_open_q;
    word_buf    = buf_id_q;
    write_beat  = 1'b0;
    pkt_inc     = 1'b0;
    drop_inc    = 1'b0;
    err_inc     = 1'b0;
    if (accept) begin
      if (bus.in_sop) begin
        if (state_q == IN_PKT) begin
          err_inc  = 1'b1;
          word_buf = buf_id_q + 8'd1;
        end else if (state_q == DROP && drop_open_q) begin
          word_buf = buf_id_q + 8'd1;
        end
        write_beat  = 1'b1;
        drop_open_d = 1'b0;
        if (bus.in_eop) begin
          pkt_inc    = 1'b1;
          buf_id_d   = word_buf + 8'd1;
          beat_cnt_d = 8'd0;
          state_d    = IDLE;
        end else begin
          buf_id_d   = word_buf;
          beat_cnt_d = 8'd1;
          state_d    = IN_PKT;
        end
      end else begin
        unique case (state_q)
          IDLE: begin
            drop_inc = 1'b1;
            err_inc  = 1'b1;
            if (!bus.in_eop) begin
              drop_open_d = 1'b0;
              state_d     = DROP;
            end
          end
          IN_PKT: begin
            if (beat_cnt_q < 8'(MAX_BEATS)) begin
              write_beat = 1'b1;
              beat_cnt_d = beat_cnt_q + 8'd1;
              if (bus.in_eop) pkt_inc = 1'b1;
            end else begin
              drop_inc = 1'b1;
              err_inc  = 1'b1;
            end
            if (bus.in_eop) begin
              buf_id_d   = buf_id_q + 8'd1;
              beat_cnt_d = 8'd0;
              state_d    = IDLE;
            end else if (!write_beat) begin
              drop_open_d = 1'b1;
              state_d     = DROP;
            end
          end
          DROP: begin
            drop_inc = 1'b1;
            if (bus.in_eop) begin
              if (drop_open_q) buf_id_d = buf_id_q + 8'd1;
              drop_open_d = 1'b0;
              beat_cnt_d  = 8'd0;
              state_d     = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end

    pkt_cnt_d  = pkt_cnt_q + {15'd0, pkt_inc};
    drop_cnt_d = (drop_inc && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
    err_cnt_d  = (err_inc && err_cnt_q != 8'hFF) ? err_cnt_q + 8'd1 : err_cnt_q;

    word.buffer = word_buf;
    word.length = bus.in_eop ? bus.in_length : 3'd0;
    word.sop    = bus.in_sop;
    word.eop    = bus.in_eop;
    word.data   = bus.in_data;
  end

  always_ff @(posedge clk_host) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      beat_cnt_q  <= 8'd0;
      buf_id_q    <= BUF_ID_INIT;
      drop_open_q <= 1'b0;
      pkt_cnt_q   <= 16'd0;
      drop_cnt_q  <= 16'd0;
      err_cnt_q   <= 8'd0;
    end else begin
      state_q     <= state_d;
      beat_cnt_q  <= beat_cnt_d;
      buf_id_q    <= buf_id_d;
      drop_open_q <= drop_open_d;
      pkt_cnt_q   <= pkt_cnt_d;
      drop_cnt_q  <= drop_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  host_fifo_skid #(.WIDTH(HOST_WORD_W)) u_skid (
    .clk_i     (clk_host),
    .rst_ni    (rst_n),
    .load_i    (accept && write_beat),
    .data_i    (word),
    .full_i    (bus.fifo_full),
    .ready_o   (in_ready),
    .wr_en_o   (bus.wr_en),
    .wr_data_o (bus.wr_data)
  );

endmodule

// File: tb/tb_host_fifo_packer.sv
// Directed and randomized checks of host_fifo_packer against a packet-level
// reference model (expected word queue plus framing counters).
module tb_host_fifo_packer;
  import host_if_pkg::*;

  localparam int MAXB = 4;

  logic clk_host = 1'b0;
  logic rst_n    = 1'b0;
  int   compared   = 0;
  int   mismatched = 0;

  host_word_t expQ[$];
  int mPkt, mDrop, mErr, mBuf, mBeats;
  bit mOpen, mDropping, mDropOwes;

  host_fifo_packer_if bus();

  host_fifo_packer #(.MAX_BEATS(MAXB), .BUF_ID_INIT(8'h00)) dut (
    .clk_host (clk_host),
    .rst_n    (rst_n),
    .bus      (bus)
  );

  always #5 clk_host = ~clk_host;

  task automatic checkOutput(input string tag, input logic [76:0] obs, input logic [76:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void modelReset();
    expQ.delete();
    mPkt = 0; mDrop = 0; mErr = 0; mBuf = 0; mBeats = 0;
    mOpen = 0; mDropping = 0; mDropOwes = 0;
  endfunction

  function automatic void pushWord(input logic s, input logic e, input logic [2:0] l,
                                   input logic [63:0] d);
    host_word_t w;
    w.buffer = 8'(mBuf);
    w.length = e ? l : 3'd0;
    w.sop    = s;
    w.eop    = e;
    w.data   = d;
    expQ.push_back(w);
  endfunction

  // Packet-level rules: one buffer id per opened packet, oversize tails and orphans dropped.
  function automatic void modelBeat(input logic s, input logic e, input logic [2:0] l,
                                    input logic [63:0] d);
    if (s) begin
      if (mOpen) begin
        mErr++;
        mBuf++;
      end else if (mDropping && mDropOwes) begin
        mBuf++;
      end
      mDropping = 0;
      pushWord(s, e, l, d);
      if (e) begin
        mPkt++; mBuf++; mOpen = 0;
      end else begin
        mOpen = 1; mBeats = 1;
      end
    end else if (mOpen) begin
      if (mBeats < MAXB) begin
        pushWord(s, e, l, d);
        mBeats++;
        if (e) begin mPkt++; mBuf++; mOpen = 0; end
      end else begin
        mDrop++; mErr++; mOpen = 0;
        if (e) mBuf++;
        else begin mDropping = 1; mDropOwes = 1; end
      end
    end else if (mDropping) begin
      mDrop++;
      if (e) begin
        if (mDropOwes) mBuf++;
        mDropping = 0;
      end
    end else begin
      mDrop++; mErr++;
      if (!e) begin mDropping = 1; mDropOwes = 0; end
    end
  endfunction

  task automatic applyStimulus(input logic rst, input logic v, input logic s, input logic e,
                               input logic [2:0] l, input logic [63:0] d, input logic f);
    logic expReady, expWr;
    logic [76:0] expData;
    @(negedge clk_host);
    rst_n = rst;
    bus.in_valid = v; bus.in_sop = s; bus.in_eop = e;
    bus.in_length = l; bus.in_data = d; bus.fifo_full = f;
    #1;
    expWr    = rst && (expQ.size() != 0) && !f;
    expReady = rst && ((expQ.size() == 0) || !f);
    expData  = (rst && expQ.size() != 0) ? expQ[0] : '0;
    checkOutput("in_ready", bus.in_ready, expReady);
    checkOutput("wr_en", bus.wr_en, expWr);
    checkOutput("wr_data", bus.wr_data, expData);
    checkOutput("pkt_cnt", bus.pkt_cnt, rst ? 16'(mPkt) : 16'd0);
    checkOutput("drop_cnt", bus.drop_cnt, rst ? ((mDrop > 65535) ? 16'hFFFF : 16'(mDrop)) : 16'd0);
    checkOutput("err_cnt", bus.err_cnt, rst ? ((mErr > 255) ? 8'hFF : 8'(mErr)) : 8'd0);
    @(posedge clk_host);
    if (!rst) modelReset();
    else begin
      if (expWr) void'(expQ.pop_front());
      if (v && expReady) modelBeat(s, e, l, d);
    end
  endtask

  initial begin
    logic [7:0] bId;
    modelReset();
    bus.in_valid = 0; bus.in_sop = 0; bus.in_eop = 0;
    bus.in_length = 0; bus.in_data = 0; bus.fifo_full = 0;

    applyStimulus(0, 1, 1, 1, 3'd1, 64'h1, 0);
    applyStimulus(0, 0, 0, 0, 3'd0, 64'h0, 0);

    applyStimulus(1, 1, 1, 1, 3'd4, 64'hDEADBEEFCAFEBABE, 0);
    #2;
    checkOutput("plan_single_word", bus.wr_data, {8'h00, 3'd4, 1'b1, 1'b1, 64'hDEADBEEFCAFEBABE});
    checkOutput("plan_single_pkt", bus.pkt_cnt, 16'd1);

    applyStimulus(1, 1, 1, 0, 3'd7, 64'hA0A0, 0);
    #2 checkOutput("plan_3beat_first", bus.wr_data, {8'h01, 3'd0, 2'b10, 64'hA0A0});
    applyStimulus(1, 1, 0, 0, 3'd7, 64'hB1B1, 0);
    applyStimulus(1, 1, 0, 1, 3'd5, 64'hC2C2, 1);
    #2;
    checkOutput("plan_full_ready", bus.in_ready, 1'b0);
    checkOutput("plan_full_hold", bus.wr_data, {8'h01, 3'd0, 2'b00, 64'hB1B1});
    applyStimulus(1, 1, 0, 1, 3'd5, 64'hC2C2, 0);
    #2 checkOutput("plan_3beat_last", bus.wr_data, {8'h01, 3'd5, 2'b01, 64'hC2C2});
    applyStimulus(1, 0, 0, 0, 3'd0, 64'h0, 0);

    applyStimulus(1, 1, 0, 1, 3'd2, 64'h0BAD, 0);
    #2;
    checkOutput("plan_orphan_wr", bus.wr_en, 1'b0);
    checkOutput("plan_orphan_drop", bus.drop_cnt, 16'd1);
    checkOutput("plan_orphan_err", bus.err_cnt, 8'd1);

    for (int i = 0; i < 6; i++)
      applyStimulus(1, 1, i == 0, i == 5, 3'd3, 64'(100 + i), 0);
    #2;
    checkOutput("plan_oversize_pkt", bus.pkt_cnt, 16'd2);
    checkOutput("plan_oversize_drop", bus.drop_cnt, 16'd3);
    checkOutput("plan_oversize_err", bus.err_cnt, 8'd2);
    applyStimulus(1, 1, 1, 1, 3'd0, 64'h5151, 0);
    #2 checkOutput("plan_after_oversize_buf", bus.wr_data[76:69], 8'h03);

    applyStimulus(1, 1, 1, 0, 3'd0, 64'h6161, 0);
    applyStimulus(1, 1, 1, 1, 3'd6, 64'h7171, 0);
    #2;
    checkOutput("plan_midsop_word", bus.wr_data, {8'h05, 3'd6, 2'b11, 64'h7171});
    checkOutput("plan_midsop_err", bus.err_cnt, 8'd3);
    checkOutput("plan_midsop_pkt", bus.pkt_cnt, 16'd4);

    applyStimulus(1, 1, 1, 1, 3'd1, 64'h8181, 1);
    applyStimulus(1, 1, 1, 1, 3'd1, 64'h9191, 1);
    applyStimulus(0, 1, 1, 1, 3'd1, 64'h9191, 1);
    applyStimulus(1, 0, 0, 0, 3'd0, 64'h0, 0);
    #2 checkOutput("plan_reset_no_write", bus.wr_en, 1'b0);

    for (int i = 0; i <= 256; i++) begin
      applyStimulus(1, 1, 1, 1, 3'd0, 64'(i), 0);
      bId = 8'(i);
      #2 checkOutput("plan_bufid_seq", bus.wr_data[76:69], bId);
    end

    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0,
                    $urandom_range(0, 4) == 0, $urandom_range(0, 2) == 0,
                    3'($urandom), {$urandom, $urandom}, $urandom_range(0, 3) == 0);
    end
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 0, 3'd0, 64'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
